mu0_mux16_reg: RTL and testbench
================================

Name: mu0_mux16_reg

Overview:
- 16-bit, 2-to-1 word selector for the MU0 datapath, used for address and ALU-operand selection.
- Q is the combinational selection of A or B under control of S.
- A clocked copy (Q_q) and a valid flag (Q_vld) are provided for registered consumers.
- One clock domain; synchronous, active-high reset.

Parameters:
- WIDTH, 16, data width of A, B, Q, Q_q (MU0 instantiates only at 16).

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- A  input  WIDTH  data word selected when S=0
- B  input  WIDTH  data word selected when S=1
- S  input  1  select: 0 -> A, 1 -> B
- Q  output  WIDTH  combinational selected word
- Q_q  output  WIDTH  registered selected word (one cycle behind Q)
- Q_vld  output  1  high when Q_q holds a value captured outside reset

Behaviour:
- Q = S ? B : A.
  - Purely combinational, zero-cycle latency.
  - Unaffected by Clk and Reset.
  - Valid even with the clock stopped.
- S is a strict 1-bit control. X/Z on S gives an X result in simulation; no priority or default word is substituted.
- Full-width selection: every bit of Q comes from the same source word, with no bitwise mixing.
  - Example: A=16'h0001, B=16'h0000, S=0 -> Q=16'h0001.
- Q_q:
  - On each rising Clk edge with Reset=1: Q_q <= 0.
  - On each rising Clk edge with Reset=0: Q_q <= (S ? B : A), sampled at that edge.
  - Latency is exactly 1 cycle from the input change to Q_q.
- Q_vld:
  - Rising edge with Reset=1: Q_vld <= 0.
  - Rising edge with Reset=0: Q_vld <= 1.
  - Stays 1 until the next reset.
- Reset mid-operation: on the reset edge, Q_q and Q_vld clear to 0 whatever A, B and S are. Q continues to track its inputs throughout.
- Reset released: the first edge with Reset=0 loads Q_q and sets Q_vld, both visible after that edge.
- Power-up: Q_q and Q_vld are undefined until the first reset edge. No initial blocks.
- No other state: no hold or enable input; Q_q updates every non-reset cycle.
- A, B and S changing together are handled as one new selection; no glitch requirement is placed on Q beyond settling within the cycle.

Optional Feature:
- Macro: MU0_MUX16_SELCHG_EN.
- When defined, an extra output Sel_chg (1 bit) is added after Q_vld, plus an internal register S_q.
  - S_q: reset to 0; otherwise S_q <= S on each rising edge.
  - Sel_chg = Q_vld & (S != S_q), combinational.
  - Sel_chg flags any cycle where the select differs from the previously sampled select.
  - Sel_chg is forced to 0 while Q_vld=0, i.e. during reset and the first cycle after it.
- When not defined:
  - Sel_chg and S_q do not exist.
  - The port list is exactly Clk, Reset, A, B, S, Q, Q_q, Q_vld.
  - Q, Q_q and Q_vld behave identically with or without the macro.

Test Plan:
- Combinational select of A, B=1:
  - A=16'h0000, B=16'h0001, S=0 -> Q=16'h0000.
  - Then S=1 -> Q=16'h0001, within the same time step, no clock required.
- Combinational select of A=1, B=0:
  - A=16'h0001, B=16'h0000, S=0 -> Q=16'h0001.
  - Then S=1 -> Q=16'h0000.
  - Repeat the toggle twice; results must be identical each time.
- Reset:
  - Hold Reset=1 for 2 edges with A=16'hFFFF, S=0 -> Q_q=16'h0000, Q_vld=0, while Q=16'hFFFF.
- Registered path:
  - Release reset with A=16'h1234, B=16'hABCD, S=1 -> after the next edge Q_q=16'hABCD, Q_vld=1.
  - Set S=0 -> Q=16'h1234 immediately; Q_q=16'h1234 only after the following edge.
- Reset mid-run:
  - With Q_q=16'hABCD, Q_vld=1, assert Reset for 1 edge -> Q_q=0, Q_vld=0.
  - Deassert Reset -> reload on the next edge.
- With MU0_MUX16_SELCHG_EN:
  - After reset and 2 stable cycles at S=0, drive S=1 -> Sel_chg=1 for exactly one cycle, then 0 while S stays 1.
  - Sel_chg=0 throughout reset.

Source files
------------

// File: rtl/mu0_mux16_reg.sv
`default_nettype none
// ============================================================================
// Module   : mu0_mux16_reg
// Brief    : MU0 2-to-1 word selector with a registered copy and valid flag.
//            Optional macro MU0_MUX16_SELCHG_EN adds the Sel_chg output.
// Revision : 1.0 - initial release
// ============================================================================
module mu0_mux16_reg #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_q,
    output logic             Q_vld
`ifdef MU0_MUX16_SELCHG_EN
    ,
    output logic             Sel_chg
`endif
);

    // Full-word select; an unknown S propagates as X in simulation.
    assign Q = S ? B : A;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q_q   <= '0;
            Q_vld <= 1'b0;
        end else begin
            Q_q   <= Q;
            Q_vld <= 1'b1;
        end
    end

`ifdef MU0_MUX16_SELCHG_EN
    logic S_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            S_q <= 1'b0;
        end else begin
            S_q <= S;
        end
    end

    // Gated by Q_vld so the cleared S_q never raises a false change after reset.
    assign Sel_chg = Q_vld & (S != S_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mu0_mux16_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mu0_mux16_reg
// Brief    : Directed self-checking bench for mu0_mux16_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mu0_mux16_reg;

    logic        Clk;
    logic        Reset;
    logic [15:0] A;
    logic [15:0] B;
    logic        S;
    logic [15:0] Q;
    logic [15:0] Q_q;
    logic        Q_vld;
`ifdef MU0_MUX16_SELCHG_EN
    logic        Sel_chg;
`endif

    int checks;
    int failures;

    mu0_mux16_reg #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .S     (S),
        .Q     (Q),
        .Q_q   (Q_q),
        .Q_vld (Q_vld)
`ifdef MU0_MUX16_SELCHG_EN
        ,
        .Sel_chg (Sel_chg)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_comb;
        A = 16'h0000; B = 16'h0001; S = 1'b0; #1;
        checks++;
        if (Q !== 16'h0000) begin failures++; $display("FAIL comb_a0_s0 got=%h exp=%h", Q, 16'h0000); end
        S = 1'b1; #1;
        checks++;
        if (Q !== 16'h0001) begin failures++; $display("FAIL comb_b1_s1 got=%h exp=%h", Q, 16'h0001); end
        A = 16'h0001; B = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            S = 1'b0; #1;
            checks++;
            if (Q !== 16'h0001) begin failures++; $display("FAIL comb_a1_s0[%0d] got=%h exp=%h", i, Q, 16'h0001); end
            S = 1'b1; #1;
            checks++;
            if (Q !== 16'h0000) begin failures++; $display("FAIL comb_b0_s1[%0d] got=%h exp=%h", i, Q, 16'h0000); end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; A = 16'hFFFF; B = 16'h0000; S = 1'b0;
        tick;
        tick;
        checks++;
        if (Q_q !== 16'h0000) begin failures++; $display("FAIL reset_q_q got=%h exp=%h", Q_q, 16'h0000); end
        checks++;
        if (Q_vld !== 1'b0) begin failures++; $display("FAIL reset_q_vld got=%b exp=%b", Q_vld, 1'b0); end
        checks++;
        if (Q !== 16'hFFFF) begin failures++; $display("FAIL reset_q_comb got=%h exp=%h", Q, 16'hFFFF); end
    endtask

    task automatic test_registered;
        Reset = 1'b0; A = 16'h1234; B = 16'hABCD; S = 1'b1; #1;
        checks++;
        if (Q_vld !== 1'b0) begin failures++; $display("FAIL reg_vld_pre_edge got=%b exp=%b", Q_vld, 1'b0); end
        tick;
        checks++;
        if (Q_q !== 16'hABCD) begin failures++; $display("FAIL reg_first_load got=%h exp=%h", Q_q, 16'hABCD); end
        checks++;
        if (Q_vld !== 1'b1) begin failures++; $display("FAIL reg_first_vld got=%b exp=%b", Q_vld, 1'b1); end
        S = 1'b0; #1;
        checks++;
        if (Q !== 16'h1234) begin failures++; $display("FAIL reg_comb_switch got=%h exp=%h", Q, 16'h1234); end
        checks++;
        if (Q_q !== 16'hABCD) begin failures++; $display("FAIL reg_hold_before_edge got=%h exp=%h", Q_q, 16'hABCD); end
        tick;
        checks++;
        if (Q_q !== 16'h1234) begin failures++; $display("FAIL reg_after_edge got=%h exp=%h", Q_q, 16'h1234); end
    endtask

    task automatic test_reset_midrun;
        S = 1'b1;
        tick;
        checks++;
        if (Q_q !== 16'hABCD || Q_vld !== 1'b1) begin
            failures++; $display("FAIL mid_preload got=%h/%b exp=%h/%b", Q_q, Q_vld, 16'hABCD, 1'b1);
        end
        Reset = 1'b1;
        tick;
        checks++;
        if (Q_q !== 16'h0000 || Q_vld !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%h/%b exp=%h/%b", Q_q, Q_vld, 16'h0000, 1'b0);
        end
        checks++;
        if (Q !== 16'hABCD) begin failures++; $display("FAIL mid_reset_comb got=%h exp=%h", Q, 16'hABCD); end
        Reset = 1'b0;
        tick;
        checks++;
        if (Q_q !== 16'hABCD || Q_vld !== 1'b1) begin
            failures++; $display("FAIL mid_reload got=%h/%b exp=%h/%b", Q_q, Q_vld, 16'hABCD, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [15:0] ve [6];
        va = '{16'h00FF, 16'h8000, 16'hFFFF, 16'h5A5A, 16'h0F0F, 16'h0001};
        vb = '{16'hFF00, 16'h0001, 16'h0000, 16'hA5A5, 16'hF0F0, 16'h7FFE};
        vs = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0};
        ve = '{16'h00FF, 16'h0001, 16'h0000, 16'h5A5A, 16'hF0F0, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            A = va[i]; B = vb[i]; S = vs[i]; #1;
            checks++;
            if (Q !== ve[i]) begin failures++; $display("FAIL b2b_comb[%0d] got=%h exp=%h", i, Q, ve[i]); end
            tick;
            checks++;
            if (Q_q !== ve[i]) begin failures++; $display("FAIL b2b_reg[%0d] got=%h exp=%h", i, Q_q, ve[i]); end
        end
    endtask

`ifdef MU0_MUX16_SELCHG_EN
    task automatic test_selchg;
        Reset = 1'b1; S = 1'b1;
        tick;
        checks++;
        if (Sel_chg !== 1'b0) begin failures++; $display("FAIL selchg_in_reset got=%b exp=%b", Sel_chg, 1'b0); end
        S = 1'b0; Reset = 1'b0;
        tick;
        tick;
        checks++;
        if (Sel_chg !== 1'b0) begin failures++; $display("FAIL selchg_stable got=%b exp=%b", Sel_chg, 1'b0); end
        S = 1'b1; #1;
        checks++;
        if (Sel_chg !== 1'b1) begin failures++; $display("FAIL selchg_pulse got=%b exp=%b", Sel_chg, 1'b1); end
        tick;
        checks++;
        if (Sel_chg !== 1'b0) begin failures++; $display("FAIL selchg_clear1 got=%b exp=%b", Sel_chg, 1'b0); end
        tick;
        checks++;
        if (Sel_chg !== 1'b0) begin failures++; $display("FAIL selchg_clear2 got=%b exp=%b", Sel_chg, 1'b0); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        Reset = 1'b0; A = '0; B = '0; S = 1'b0;
        test_comb;
        test_reset;
        test_registered;
        test_reset_midrun;
        test_back_to_back;
`ifdef MU0_MUX16_SELCHG_EN
        test_selchg;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
